// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Host-side bundle for the serial BCD add/sub controller.
// Optional macro BCD_CIN_EN adds the cin request signal.
interface bcd_serial_addsub_ctrl_if #(
  parameter int NDIG = 2
);
  logic              start;
  logic              mode;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
`ifdef BCD_CIN_EN
  logic              cin;
`endif
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] result;
  logic              cout;
  logic              neg;
  logic              err;

`ifdef BCD_CIN_EN
  modport master (output start, mode, a, b, cin, input busy, done, result, cout, neg, err);
  modport slave  (input start, mode, a, b, cin, output busy, done, result, cout, neg, err);
`else
  modport master (output start, mode, a, b, input busy, done, result, cout, neg, err);
  modport slave  (input start, mode, a, b, output busy, done, result, cout, neg, err);
`endif
endinterface

// File: rtl/bcd_serial_addsub_ctrl.sv
// Multi-digit BCD add/subtract using one shared digit slice, LSD first.
// Optional macro BCD_CIN_EN: latches cin as the initial carry for add.
module bcd_serial_addsub_ctrl #(
  parameter int NDIG = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_serial_addsub_ctrl_if.slave       bus
);
  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            mode_reg;
  logic [IW-1:0]   idx_reg;
  logic            carry_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [W-1:0]    result_reg;
  logic            cout_reg;
  logic            neg_reg;
  logic            err_reg;

  logic [IW+1:0]   base;
  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [4:0]      dig_sum;
  logic            dig_carry;
  logic [3:0]      dig_new;
  logic            last_dig;
  logic [2*NDIG-1:0] dig_bad;
  logic            any_bad;
  logic            cin_init;

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.cout   = cout_reg;
  assign bus.neg    = neg_reg;
  assign bus.err    = err_reg;

`ifdef BCD_CIN_EN
  assign cin_init = bus.cin;
`else
  assign cin_init = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_chk
      assign dig_bad[gi]        = bus.a[4*gi +: 4] > 4'd9;
      assign dig_bad[NDIG + gi] = bus.b[4*gi +: 4] > 4'd9;
    end
  endgenerate
  assign any_bad  = |dig_bad;
  assign last_dig = (idx_reg == IW'(NDIG - 1));

  // Shared digit slice: ADD uses a + (b or 9-b), FIX recomplements the stored digit.
  always_comb begin
    base  = {idx_reg, 2'b00};
    dig_a = a_reg[base +: 4];
    dig_b = mode_reg ? (4'd9 - b_reg[base +: 4]) : b_reg[base +: 4];
    if (state_reg == FIX) begin
      dig_a = 4'd9 - result_reg[base +: 4];
      dig_b = 4'd0;
    end
    dig_sum   = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_reg};
    dig_carry = (dig_sum > 5'd9);
    dig_new   = dig_carry ? (dig_sum[3:0] + 4'd6) : dig_sum[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= 1'b0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && !busy_reg) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            mode_reg <= bus.mode;
            idx_reg  <= '0;
            err_reg  <= any_bad;
            if (any_bad) begin
              result_reg <= '0;
              cout_reg   <= 1'b0;
              neg_reg    <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end else begin
              carry_reg <= bus.mode ? 1'b1 : cin_init;
              busy_reg  <= 1'b1;
              state_reg <= ADD;
            end
          end
        end
        ADD: begin
          result_reg[base +: 4] <= dig_new;
          carry_reg             <= dig_carry;
          if (last_dig) begin
            if (!mode_reg || dig_carry) begin
              cout_reg  <= mode_reg ? 1'b0 : dig_carry;
              neg_reg   <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              // No end-around carry: A<B, so recomplement the digits in place.
              cout_reg  <= 1'b0;
              neg_reg   <= 1'b1;
              idx_reg   <= '0;
              carry_reg <= 1'b1;
              state_reg <= FIX;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        FIX: begin
          result_reg[base +: 4] <= dig_new;
          carry_reg             <= dig_carry;
          if (last_dig) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Randomized bench for bcd_serial_addsub_ctrl against a decimal-arithmetic model.
// Honours BCD_CIN_EN when defined.
module tb_bcd_serial_addsub_ctrl;
  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;
`ifdef BCD_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_addsub_ctrl_if #(.NDIG(NDIG)) bus ();
  bcd_serial_addsub_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 1'b0;
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  task automatic do_op(input bit m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit ci, input bit poke);
    int           modulus = 1;
    int           x, y, s, lat, busy_n;
    bit           bad;
    logic [W-1:0] e_res;
    bit           e_cout, e_neg, e_err;
    int           e_lat;

    for (int i = 0; i < NDIG; i++) modulus = modulus * 10;
    x   = bcd2int(av);
    y   = bcd2int(bv);
    bad = has_bad(av) || has_bad(bv);
    e_cout = 1'b0; e_neg = 1'b0; e_err = 1'b0;
    if (bad) begin
      e_res = '0; e_err = 1'b1; e_lat = 1;
    end else if (!m) begin
      s      = x + y + ((CIN_EN && ci) ? 1 : 0);
      e_res  = int2bcd(s % modulus);
      e_cout = (s >= modulus);
      e_lat  = NDIG + 1;
    end else if (x >= y) begin
      e_res = int2bcd(x - y); e_lat = NDIG + 1;
    end else begin
      e_res = int2bcd(y - x); e_neg = 1'b1; e_lat = 2 * NDIG + 1;
    end

    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = m; bus.a = av; bus.b = bv;
`ifdef BCD_CIN_EN
    bus.cin = ci;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; busy_n = 0;
    while (!bus.done && lat < 4 * NDIG + 8) begin
      if (bus.busy) busy_n++;
      if (poke) begin
        bus.start = 1'b1; bus.mode = 1'($urandom);
        bus.a = W'($urandom); bus.b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    $display("op mode=%0d a=%h b=%h cin=%0d -> result=%h cout=%0d neg=%0d err=%0d lat=%0d",
             m, av, bv, ci, bus.result, bus.cout, bus.neg, bus.err, lat);
    check("latency", 32'(lat), 32'(e_lat));
    check("busy_cycles", 32'(busy_n), 32'(e_lat - 1));
    check("result", 32'(bus.result), 32'(e_res));
    check("cout", 32'(bus.cout), 32'(e_cout));
    check("neg", 32'(bus.neg), 32'(e_neg));
    check("err", 32'(bus.err), 32'(e_err));
    if (poke) begin
      // start is still high through the DONE cycle and must be ignored there too
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("poke_done_pulse", 32'(bus.done), 32'd0);
      check("poke_busy", 32'(bus.busy), 32'd0);
      check("poke_hold", 32'(bus.result), 32'(e_res));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
`ifdef BCD_CIN_EN
    bus.cin = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.cout, bus.neg, bus.err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 8'h45, 8'h38, 1'b0, 1'b0);
    do_op(1'b0, 8'h99, 8'h01, 1'b0, 1'b0);
    do_op(1'b0, 8'h45, 8'h38, 1'b1, 1'b0);
    do_op(1'b1, 8'h52, 8'h17, 1'b0, 1'b0);
    do_op(1'b1, 8'h17, 8'h52, 1'b0, 1'b0);
    do_op(1'b1, 8'h09, 8'h09, 1'b0, 1'b0);
    do_op(1'b0, 8'h1A, 8'h05, 1'b0, 1'b0);
    do_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    do_op(1'b0, 8'h23, 8'h45, 1'b0, 1'b1);
    do_op(1'b1, 8'h00, 8'h99, 1'b0, 1'b1);

    // Abort in the middle of the recomplement pass of 17-52.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 1'b1; bus.a = 8'h17; bus.b = 8'h52;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", 32'({bus.done, bus.cout, bus.neg, bus.err}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(1'b0, 8'h45, 8'h38, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom), rand_bcd(), rand_bcd(), 1'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
